// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC-side fetch responder driving an instruction-memory read bus
// Optional bus-read timeout enabled by defining IFETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PCAddr,
    input  logic              GetInstruction,
    input  logic              Flush,
    input  logic              InstrAccept,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    input  logic [DATA_W-1:0] MemData,
    input  logic              MemReady,
    output logic [DATA_W-1:0] Instr,
    output logic              InstrValid,
    output logic              Busy,
    output logic              FetchFault
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

    state_t            state, nxt;
    logic [ADDR_W-1:0] n_addr;
    logic              n_read;
    logic [DATA_W-1:0] n_instr;
    logic              n_valid;
    logic              n_fault;
    logic              timed_out;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tcnt, n_tcnt;

    // Fires on the last permitted waiting cycle so the abort lands on the TIMEOUT_CYCLES-th edge.
    assign timed_out = (state == REQ || state == DRAIN) && !MemReady &&
                       (tcnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        n_tcnt = tcnt;
        if (nxt != state)
            n_tcnt = '0;
        else if ((state == REQ || state == DRAIN) && !MemReady)
            n_tcnt = tcnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else
            tcnt <= n_tcnt;
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        nxt     = state;
        n_addr  = MemAddr;
        n_read  = MemRead;
        n_instr = Instr;
        n_valid = InstrValid;
        n_fault = 1'b0;
        unique case (state)
            IDLE: begin
                if (!Flush && GetInstruction) begin
                    if (PCAddr[1:0] == 2'b00) begin
                        n_addr = {PCAddr[ADDR_W-1:2], 2'b00};
                        n_read = 1'b1;
                        nxt    = REQ;
                    end else begin
                        n_fault = 1'b1;
                    end
                end
            end
            REQ: begin
                if (MemReady) begin
                    n_read = 1'b0;
                    if (Flush) begin
                        nxt = IDLE;
                    end else begin
                        n_instr = MemData;
                        n_valid = 1'b1;
                        nxt     = HOLD;
                    end
                end else if (timed_out) begin
                    n_read  = 1'b0;
                    n_fault = 1'b1;
                    nxt     = IDLE;
                end else if (Flush) begin
                    // The bus read cannot be withdrawn, so wait out its completion.
                    nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (MemReady) begin
                    n_read = 1'b0;
                    nxt    = IDLE;
                end else if (timed_out) begin
                    n_read  = 1'b0;
                    n_fault = 1'b1;
                    nxt     = IDLE;
                end
            end
            HOLD: begin
                if (Flush) begin
                    n_valid = 1'b0;
                    nxt     = IDLE;
                end else if (InstrAccept) begin
                    n_valid = 1'b0;
                    nxt     = IDLE;
                    if (GetInstruction) begin
                        if (PCAddr[1:0] == 2'b00) begin
                            n_addr = {PCAddr[ADDR_W-1:2], 2'b00};
                            n_read = 1'b1;
                            nxt    = REQ;
                        end else begin
                            n_fault = 1'b1;
                        end
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            MemAddr    <= '0;
            MemRead    <= 1'b0;
            Instr      <= '0;
            InstrValid <= 1'b0;
            Busy       <= 1'b0;
            FetchFault <= 1'b0;
        end else begin
            state      <= nxt;
            MemAddr    <= n_addr;
            MemRead    <= n_read;
            Instr      <= n_instr;
            InstrValid <= n_valid;
            Busy       <= (nxt != IDLE);
            FetchFault <= n_fault;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCAddr;
    logic        GetInstruction;
    logic        Flush;
    logic        InstrAccept;
    logic [31:0] MemAddr;
    logic        MemRead;
    logic [31:0] MemData;
    logic        MemReady;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        Busy;
    logic        FetchFault;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst), .PCAddr(PCAddr), .GetInstruction(GetInstruction),
        .Flush(Flush), .InstrAccept(InstrAccept), .MemAddr(MemAddr), .MemRead(MemRead),
        .MemData(MemData), .MemReady(MemReady), .Instr(Instr), .InstrValid(InstrValid),
        .Busy(Busy), .FetchFault(FetchFault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("instr", Instr, e.data);
        end
    endtask

    // Memory responder: holds MemReady off for 'waits' cycles, then returns the scoreboard head.
    task automatic serve(input int waits);
        for (int i = 0; i < waits; i++) begin
            chk("wait_read", {31'd0, MemRead}, 32'd1);
            chk("wait_addr", MemAddr, exp_q[0].addr);
            chk("wait_busy", {31'd0, Busy}, 32'd1);
            tick();
        end
        chk("req_addr", MemAddr, exp_q[0].addr);
        MemReady = 1'b1;
        MemData  = exp_q[0].data;
        tick();
        MemReady = 1'b0;
        MemData  = 32'h0;
        chk("valid_set", {31'd0, InstrValid}, 32'd1);
        chk("read_drop", {31'd0, MemRead}, 32'd0);
        pop_check();
    endtask

    task automatic strobe(input logic [31:0] addr);
        PCAddr         = addr;
        GetInstruction = 1'b1;
        tick();
        GetInstruction = 1'b0;
    endtask

    task automatic accept();
        InstrAccept = 1'b1;
        tick();
        InstrAccept = 1'b0;
        chk("accept_valid", {31'd0, InstrValid}, 32'd0);
        chk("accept_busy", {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; PCAddr = 0; GetInstruction = 0; Flush = 0; InstrAccept = 0;
        MemData = 0; MemReady = 0;
        repeat (2) tick();
        chk("rst_read", {31'd0, MemRead}, 32'd0);
        chk("rst_valid", {31'd0, InstrValid}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_fault", {31'd0, FetchFault}, 32'd0);
        chk("rst_addr", MemAddr, 32'd0);
        chk("rst_instr", Instr, 32'd0);
        rst = 1'b0;
        tick();

        // Asynchronous reset while a read is outstanding
        strobe(32'h80);
        chk("pre_rst_read", {31'd0, MemRead}, 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("arst_read", {31'd0, MemRead}, 32'd0);
        chk("arst_busy", {31'd0, Busy}, 32'd0);
        chk("arst_addr", MemAddr, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_idle", {31'd0, Busy}, 32'd0);

        // Zero-wait fetch, held without accept for one cycle
        exp_q.push_back('{addr: 32'h28, data: 32'hDEADBEEF});
        strobe(32'h28);
        chk("zw_read", {31'd0, MemRead}, 32'd1);
        chk("zw_valid0", {31'd0, InstrValid}, 32'd0);
        serve(0);
        tick();
        chk("hold_valid", {31'd0, InstrValid}, 32'd1);
        chk("hold_busy", {31'd0, Busy}, 32'd1);
        accept();

        // Three wait states, then back-to-back accept+request
        exp_q.push_back('{addr: 32'h10, data: 32'hA5A50010});
        strobe(32'h10);
        serve(3);
        exp_q.push_back('{addr: 32'h14, data: 32'h0BADF00D});
        InstrAccept = 1'b1;
        strobe(32'h14);
        InstrAccept = 1'b0;
        chk("b2b_read", {31'd0, MemRead}, 32'd1);
        chk("b2b_valid", {31'd0, InstrValid}, 32'd0);
        chk("b2b_busy", {31'd0, Busy}, 32'd1);
        serve(1);
        accept();

        // Misaligned request
        strobe(32'h21);
        chk("mis_fault", {31'd0, FetchFault}, 32'd1);
        chk("mis_read", {31'd0, MemRead}, 32'd0);
        chk("mis_valid", {31'd0, InstrValid}, 32'd0);
        tick();
        chk("mis_pulse", {31'd0, FetchFault}, 32'd0);
        chk("mis_read2", {31'd0, MemRead}, 32'd0);

        // Flush with request in IDLE drops the request; stray MemReady ignored
        Flush = 1'b1;
        MemReady = 1'b1;
        strobe(32'h50);
        Flush = 1'b0;
        MemReady = 1'b0;
        chk("fidle_read", {31'd0, MemRead}, 32'd0);
        chk("fidle_valid", {31'd0, InstrValid}, 32'd0);

        // Flush in REQ drains the outstanding read
        strobe(32'h40);
        chk("fr_addr", MemAddr, 32'h40);
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("drain_read", {31'd0, MemRead}, 32'd1);
        chk("drain_busy", {31'd0, Busy}, 32'd1);
        GetInstruction = 1'b1;
        tick();
        GetInstruction = 1'b0;
        chk("drain_hold", {31'd0, MemRead}, 32'd1);
        chk("drain_addr", MemAddr, 32'h40);
        MemReady = 1'b1;
        MemData  = 32'h12345678;
        tick();
        MemReady = 1'b0;
        chk("drain_done_read", {31'd0, MemRead}, 32'd0);
        chk("drain_done_valid", {31'd0, InstrValid}, 32'd0);
        chk("drain_done_busy", {31'd0, Busy}, 32'd0);
        exp_q.push_back('{addr: 32'h30, data: 32'hC0DE0030});
        strobe(32'h30);
        serve(2);

        // Flush together with accept in HOLD delivers nothing
        Flush = 1'b1;
        InstrAccept = 1'b1;
        tick();
        Flush = 1'b0;
        InstrAccept = 1'b0;
        chk("fhold_valid", {31'd0, InstrValid}, 32'd0);
        chk("fhold_busy", {31'd0, Busy}, 32'd0);

`ifdef IFETCH_TIMEOUT_EN
        begin
            int hi = 0;
            strobe(32'h44);
            while (MemRead && hi < 40) begin
                hi++;
                tick();
            end
            chk("to_cycles", hi, 32'd15);
            chk("to_fault", {31'd0, FetchFault}, 32'd1);
            chk("to_valid", {31'd0, InstrValid}, 32'd0);
            chk("to_busy", {31'd0, Busy}, 32'd0);
            tick();
            chk("to_pulse", {31'd0, FetchFault}, 32'd0);
        end
`endif

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
